wb_rom_arbiter: RTL

//  Two-master Wishbone arbiter that shares one 8-bit ROM slave port between the CPU (m0) and a

---
 rtl/wb_rom_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_rom_arbiter.sv
// rtl/wb_rom_arbiter.sv - two-master round-robin Wishbone arbiter for a shared ROM slave port
module wb_rom_arbiter #(
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 12,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [WB_ADDR_WIDTH-1:0] s_adr_o,
  output logic [WB_DATA_WIDTH-1:0] s_dat_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_dat_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TERM_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [7:0]               count_q, count_d;
  logic                     grant_m1;
  logic                     s_stb_d, s_we_d;
  logic [WB_ADDR_WIDTH-1:0] s_adr_d;
  logic [WB_DATA_WIDTH-1:0] s_dat_d;
  logic                     m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
  logic [WB_DATA_WIDTH-1:0] m0_dat_d, m1_dat_d;

  // On a tie the master that did not win last time gets the grant
  assign grant_m1 = m1_stb_i & (~m0_stb_i | ~last_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    count_d  = count_q;
    s_stb_d  = s_stb_o;
    s_we_d   = s_we_o;
    s_adr_d  = s_adr_o;
    s_dat_d  = s_dat_o;
    m0_dat_d = m0_dat_o;
    m1_dat_d = m1_dat_o;
    m0_ack_d = 1'b0;
    m0_err_d = 1'b0;
    m1_ack_d = 1'b0;
    m1_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_stb_i | m1_stb_i) begin
          owner_d = grant_m1;
          last_d  = grant_m1;
          s_we_d  = grant_m1 ? m1_we_i  : m0_we_i;
          s_adr_d = grant_m1 ? m1_adr_i : m0_adr_i;
          s_dat_d = grant_m1 ? m1_dat_i : m0_dat_i;
          s_stb_d = 1'b1;
          count_d = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Ack takes priority over a coincident terminal count
        if (s_ack_i) begin
          if (owner_q) begin
            m1_dat_d = s_dat_i;
            m1_ack_d = 1'b1;
          end else begin
            m0_dat_d = s_dat_i;
            m0_ack_d = 1'b1;
          end
          s_stb_d = 1'b0;
          state_d = DONE;
        end else begin
          count_d = count_q + 8'd1;
          if (count_q == TERM_COUNT) begin
            m1_err_d = owner_q;
            m0_err_d = ~owner_q;
            s_stb_d  = 1'b0;
            state_d  = DONE;
          end
        end
      end
      // The slave's trailing ack lands here and is dropped
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      count_q  <= 8'd0;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_adr_o  <= '0;
      s_dat_o  <= '0;
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m0_dat_o <= '0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      m1_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      s_stb_o  <= s_stb_d;
      s_we_o   <= s_we_d;
      s_adr_o  <= s_adr_d;
      s_dat_o  <= s_dat_d;
      m0_ack_o <= m0_ack_d;
      m0_err_o <= m0_err_d;
      m0_dat_o <= m0_dat_d;
      m1_ack_o <= m1_ack_d;
      m1_err_o <= m1_err_d;
      m1_dat_o <= m1_dat_d;
    end
  end

endmodule
